fft_in_feeder: RTL and testbench



---
 rtl/fft_pkg.sv | 22 ++
 rtl/sample_fifo.sv | 52 +++++
 rtl/fft_in_feeder.sv | 118 +++++++++++
 tb/tb_fft_in_feeder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, sample record and feeder state encoding
package fft_pkg;

  localparam int FRAME_LEN = 16;
  localparam int SAMPLE_W  = 16;
  localparam int IDX_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_SEND = 3'b010,
    ST_PAD  = 3'b100
  } feeder_state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] re;
    logic [SAMPLE_W-1:0] im;
    logic                last;
  } sample_t;

  localparam int SAMPLE_BITS = $bits(sample_t);

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous FIFO with occupancy count, head read straight from storage
module sample_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only entries below count are ever presented.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fft_in_feeder.sv
// rtl/fft_in_feeder.sv - buffers upstream samples and drives the FFT core push/stall port
// Optional zero padding of short frames: FFT_FEEDER_ZERO_PAD_EN.
module fft_in_feeder #(
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = fft_pkg::FRAME_LEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [fft_pkg::SAMPLE_W-1:0] s_real,
  input  logic [fft_pkg::SAMPLE_W-1:0] s_imag,
  input  logic                         s_last,
  output logic                         in_push,
  output logic [fft_pkg::SAMPLE_W-1:0] in_real,
  output logic [fft_pkg::SAMPLE_W-1:0] in_imag,
  input  logic                         in_stall,
  output logic [fft_pkg::IDX_W-1:0]    sample_idx,
  output logic                         frame_done,
  output logic [7:0]                   frame_count,
  output logic                         frame_err
);

  import fft_pkg::*;

  localparam int                CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);

  feeder_state_t    state;
  feeder_state_t    state_nxt;
  sample_t          wr_sample;
  sample_t          head;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             wr;
  logic             pop;
  logic             xfer;
  logic             at_last_idx;

  assign wr          = s_valid && s_ready && !fifo_full;
  assign xfer        = in_push && !in_stall;
  assign pop         = xfer && (state == ST_SEND) && !fifo_empty;
  assign at_last_idx = (sample_idx == LAST_IDX);
  assign wr_sample   = '{re: s_real, im: s_imag, last: s_last};

  sample_fifo #(
    .WIDTH (SAMPLE_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr),
    .wr_data (wr_sample),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    count_nxt = fifo_count;
    if (wr && !pop)      count_nxt = fifo_count + 1'b1;
    else if (pop && !wr) count_nxt = fifo_count - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    in_push   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        in_push = 1'b1;
        if (pop && (fifo_count == CNT_W'(1)) && !wr) state_nxt = ST_IDLE;
`ifdef FFT_FEEDER_ZERO_PAD_EN
        if (pop && head.last && !at_last_idx) state_nxt = ST_PAD;
`endif
      end
`ifdef FFT_FEEDER_ZERO_PAD_EN
      ST_PAD: begin
        in_push = 1'b1;
        if (xfer && at_last_idx) state_nxt = (count_nxt != '0) ? ST_SEND : ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outside SEND the core sees zeros, which doubles as the padding value.
  assign in_real = (state == ST_SEND) ? head.re : '0;
  assign in_imag = (state == ST_SEND) ? head.im : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      s_ready     <= 1'b0;
      sample_idx  <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      frame_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      s_ready    <= (count_nxt < CNT_W'(DEPTH));
      frame_done <= xfer && at_last_idx;
      if (xfer) sample_idx <= sample_idx + 1'b1;
      if (xfer && at_last_idx) frame_count <= frame_count + 1'b1;
      if (pop && at_last_idx && !head.last) frame_err <= 1'b1;
`ifndef FFT_FEEDER_ZERO_PAD_EN
      if (pop && head.last && !at_last_idx) frame_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_fft_in_feeder.sv
// tb/tb_fft_in_feeder.sv - randomized bench for fft_in_feeder against a queue-based frame model
module tb_fft_in_feeder;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
  } smp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_real = '0;
  logic [15:0] s_imag = '0;
  logic        s_last = 1'b0;
  logic        in_push;
  logic [15:0] in_real;
  logic [15:0] in_imag;
  logic        in_stall = 1'b0;
  logic [3:0]  sample_idx;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        frame_err;

  always #5 clk = ~clk;

  fft_in_feeder #(.DEPTH(DEPTH), .FRAME_LEN(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_real      (s_real),
    .s_imag      (s_imag),
    .s_last      (s_last),
    .in_push     (in_push),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .in_stall    (in_stall),
    .sample_idx  (sample_idx),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .frame_err   (frame_err)
  );

  smp_t src[$];
  smp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_idx, m_pad, m_count;
  bit   m_err, m_done, m_ready, m_push;
  int   cyc = 0, n_xfer = 0, first_xfer = -1, last_xfer = 0;
  int   n_zero = 0, n_done = 0;
  bit   seen_ready_low = 0, seen_wrap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    src.delete();
    m_idx = 0; m_pad = 0; m_count = 0;
    m_err = 0; m_done = 0; m_ready = 0; m_push = 0;
  endtask

  task automatic add_frame(input int len, input int last_at, input int mode);
    for (int i = 0; i < len; i++) begin
      smp_t s;
      case (mode)
        1: begin s.re = 16'(i);     s.im = 16'(-i);      end
        2: begin s.re = 16'(i + 1); s.im = 16'(-(i + 1)); end
        default: begin s.re = 16'($urandom); s.im = 16'($urandom); end
      endcase
      s.last = (i == last_at);
      src.push_back(s);
    end
  endtask

  task automatic check_outputs();
    check("s_ready", s_ready, m_ready);
    check("in_push", in_push, m_push);
    check("sample_idx", sample_idx, m_idx);
    check("frame_done", frame_done, m_done);
    check("frame_count", frame_count, m_count);
    check("frame_err", frame_err, m_err);
    if (m_push) begin
      check("in_real", in_real, (m_pad > 0) ? 16'h0 : q[0].re);
      check("in_imag", in_imag, (m_pad > 0) ? 16'h0 : q[0].im);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic do_cycle(input int valid_pct, input int stall_pct);
    bit   up, core;
    smp_t e;
    if (src.size() > 0 && $urandom_range(99) < valid_pct) begin
      s_valid = 1'b1; s_real = src[0].re; s_imag = src[0].im; s_last = src[0].last;
    end else begin
      s_valid = 1'b0; s_real = 16'($urandom); s_imag = 16'($urandom); s_last = 1'($urandom);
    end
    in_stall = ($urandom_range(99) < stall_pct);
    up   = s_valid && m_ready;
    core = m_push && !in_stall;
    m_done = 0;
    if (core) begin
      n_xfer++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      if (in_real == 16'h0 && in_imag == 16'h0) n_zero++;
      if (m_pad > 0) m_pad--;
      else begin
        e = q.pop_front();
        if (m_idx == 15 && !e.last) m_err = 1;
        if (m_idx != 15 && e.last) begin
`ifdef FFT_FEEDER_ZERO_PAD_EN
          m_pad = 15 - m_idx;
`else
          m_err = 1;
`endif
        end
      end
      if (m_idx == 15) begin
        m_done = 1;
        m_count = (m_count + 1) % 256;
        if (m_count == 0) seen_wrap = 1;
      end
      m_idx = (m_idx + 1) % 16;
    end
    if (up) q.push_back(src.pop_front());
    @(posedge clk);
    @(negedge clk);
    cyc++;
    m_ready = (q.size() < DEPTH);
    m_push  = (m_pad > 0) || (q.size() > 0);
    if (s_ready === 1'b0) seen_ready_low = 1;
    if (frame_done === 1'b1) n_done++;
    check_outputs();
  endtask

  task automatic run_drain(input int valid_pct, input int stall_pct, input int budget);
    int n = 0;
    while ((src.size() > 0 || q.size() > 0 || m_pad > 0) && n < budget) begin
      do_cycle(valid_pct, stall_pct);
      n++;
    end
    check("drained", (src.size() == 0 && q.size() == 0 && m_pad == 0), 1);
  endtask

  // Reset is applied between clock edges so its effect must show without a clock.
  task automatic do_reset();
    #2;
    reset = 1'b0; s_valid = 1'b0; in_stall = 1'b0;
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_in_push", in_push, 0);
    check("rst_in_real", in_real, 0);
    check("rst_in_imag", in_imag, 0);
    check("rst_idx", sample_idx, 0);
    check("rst_done", frame_done, 0);
    check("rst_count", frame_count, 0);
    check("rst_err", frame_err, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    add_frame(16, 15, 1);
    n_xfer = 0; first_xfer = -1; n_done = 0;
    run_drain(100, 0, 100);
    check("b2b_xfers", n_xfer, 16);
    check("b2b_span", last_xfer - first_xfer + 1, 16);
    check("b2b_done_pulses", n_done, 1);
    check("b2b_count", frame_count, 1);
    check("b2b_err", frame_err, 0);

    add_frame(16, 15, 0);
    n_xfer = 0; seen_ready_low = 0;
    repeat (3) do_cycle(100, 0);
    repeat (8) do_cycle(100, 100);
    run_drain(100, 0, 200);
    check("stall_ready_drop", seen_ready_low, 1);
    check("stall_xfers", n_xfer, 16);
    check("stall_count", frame_count, 2);

    do_reset();
    add_frame(16, -1, 0);
    run_drain(100, 30, 300);
    check("miss_last_err", frame_err, 1);
    check("miss_last_idx", sample_idx, 0);

    do_reset();
    add_frame(10, 9, 2);
    n_zero = 0;
    run_drain(100, 30, 300);
`ifdef FFT_FEEDER_ZERO_PAD_EN
    check("early_last_err", frame_err, 0);
    check("early_last_zeros", n_zero, 6);
    check("early_last_count", frame_count, 1);
`else
    check("early_last_err", frame_err, 1);
    check("early_last_zeros", n_zero, 0);
    check("early_last_idx", sample_idx, 10);
`endif

    do_reset();
    add_frame(16, 15, 0);
    n_xfer = 0;
    for (int k = 0; k < 50 && n_xfer < 5; k++) do_cycle(100, 0);
    check("pre_reset_xfers", n_xfer, 5);
    do_reset();
    add_frame(16, 15, 0);
    run_drain(80, 20, 400);
    check("post_reset_idx", sample_idx, 0);
    check("post_reset_count", frame_count, 1);

    do_reset();
    seen_wrap = 0;
    repeat (257) add_frame(16, 15, 0);
    run_drain(85, 20, 20000);
    check("wrap_seen", seen_wrap, 1);
    check("wrap_count", frame_count, 1);
    check("wrap_err", frame_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
